// File: rtl/apuf_eval_ctrl_pkg.sv
// Shared types and helpers for the arbiter-PUF evaluation controller.
package apuf_eval_ctrl_pkg;

    localparam int unsigned VOTE_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StSettle,
        StSample,
        StDone
    } state_e;

    // Returns at least 1 so a counter never collapses to zero width.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/apuf_bit_vote.sv
// Per-response-bit synchroniser, ones counter and majority/instability decode.
module apuf_bit_vote
    import apuf_eval_ctrl_pkg::*;
#(
    parameter int unsigned N_EVAL = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic clear,
    input  logic sample,
    output logic maj,
    output logic unstable
);

    (* ASYNC_REG = "TRUE" *) logic sync1_q;
    (* ASYNC_REG = "TRUE" *) logic sync2_q;
    logic [VOTE_W-1:0] ones_q;
    logic [VOTE_W-1:0] ones_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        ones_d = ones_q;
        if (clear) begin
            ones_d = '0;
        end else if (sample) begin
            ones_d = ones_q + VOTE_W'(sync2_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign maj      = (ones_q >= VOTE_W'((N_EVAL + 1) / 2));
    assign unstable = (ones_q != '0) && (ones_q != VOTE_W'(N_EVAL));

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Challenge sequencer for the arbiter-PUF array: timed excitation, repeated sampling, majority vote.
module apuf_eval_ctrl
    import apuf_eval_ctrl_pkg::*;
#(
    parameter int unsigned C_LENGTH   = 64,
    parameter int unsigned R_LENGTH   = 64,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned N_EVAL     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chal_valid,
    output logic                chal_ready,
    input  logic [C_LENGTH-1:0] chal_in,
    output logic [C_LENGTH-1:0] puf_challenge,
    output logic                puf_ipulse,
    input  logic [R_LENGTH-1:0] puf_response,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [R_LENGTH-1:0] resp_out,
    output logic [R_LENGTH-1:0] resp_unstable,
    output logic                busy
);

    localparam int unsigned PH_W = clog2(max3(SETUP_CYC, PULSE_CYC, SETTLE_CYC) + 1);

    state_e              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [VOTE_W-1:0]   eval_q, eval_d;
    logic [C_LENGTH-1:0] chal_q, chal_d;
    logic                ipulse_q;
    logic                resp_valid_q, resp_valid_d;
    logic [R_LENGTH-1:0] resp_out_q, resp_out_d;
    logic [R_LENGTH-1:0] unstable_q, unstable_d;
    logic                vote_clear;
    logic                vote_sample;
    logic [R_LENGTH-1:0] maj_vec;
    logic [R_LENGTH-1:0] unst_vec;

    for (genvar i = 0; i < R_LENGTH; i++) begin : g_vote
        apuf_bit_vote #(
            .N_EVAL(N_EVAL)
        ) u_vote (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (puf_response[i]),
            .clear   (vote_clear),
            .sample  (vote_sample),
            .maj     (maj_vec[i]),
            .unstable(unst_vec[i])
        );
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        eval_d       = eval_q;
        chal_d       = chal_q;
        resp_valid_d = resp_valid_q;
        resp_out_d   = resp_out_q;
        unstable_d   = unstable_q;
        vote_clear   = 1'b0;
        vote_sample  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (chal_valid) begin
                    chal_d     = chal_in;
                    vote_clear = 1'b1;
                    eval_d     = '0;
                    phase_d    = '0;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (phase_q == PH_W'(SETUP_CYC - 1)) begin
                    phase_d = '0;
                    state_d = StPulse;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StPulse: begin
                if (phase_q == PH_W'(PULSE_CYC - 1)) begin
                    phase_d = '0;
                    state_d = StSettle;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StSettle: begin
                if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
                    phase_d = '0;
                    state_d = StSample;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StSample: begin
                vote_sample = 1'b1;
                if (eval_q == VOTE_W'(N_EVAL - 1)) begin
                    state_d = StDone;
                end else begin
                    eval_d  = eval_q + 1'b1;
                    state_d = StSetup;
                end
            end
            StDone: begin
                // First DONE cycle registers the vote; the counters are final by then.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_out_d   = maj_vec;
                    unstable_d   = unst_vec;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            eval_q       <= '0;
            chal_q       <= '0;
            ipulse_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_out_q   <= '0;
            unstable_q   <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            eval_q       <= eval_d;
            chal_q       <= chal_d;
            ipulse_q     <= (state_d == StPulse);
            resp_valid_q <= resp_valid_d;
            resp_out_q   <= resp_out_d;
            unstable_q   <= unstable_d;
        end
    end

    assign chal_ready    = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign puf_challenge = chal_q;
    assign puf_ipulse    = ipulse_q;
    assign resp_valid    = resp_valid_q;
    assign resp_out      = resp_out_q;
    assign resp_unstable = unstable_q;

endmodule
